// File: rtl/tribus_arbiter_if.sv
// Bus-side signal bundle for tribus_arbiter: request levels in, one-hot grants/enables out.
// master = arbiter side, slave = requester side.
interface tribus_arbiter_if #(
  parameter int unsigned N = 4
);
  localparam int unsigned OW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]  req;
  logic [N-1:0]  gnt;
  logic [N-1:0]  oe;
  logic          busy;
  logic [OW-1:0] owner;

  modport master (
    input  req,
    output gnt,
    output oe,
    output busy,
    output owner
  );

  modport slave (
    output req,
    input  gnt,
    input  oe,
    input  busy,
    input  owner
  );
endinterface

// File: rtl/tribus_arbiter.sv
// Round-robin owner arbiter for a shared tristate bus, with a turnaround gap between owners.
// Optional feature: define ARB_HOLD_LIMIT_EN to revoke a grant held MAXHOLD cycles while others wait.
module tribus_arbiter #(
  parameter int unsigned N       = 4,
  parameter int unsigned TURN    = 1,
  parameter int unsigned MAXHOLD = 8
) (
  input  logic             clk,
  input  logic             rst,
  tribus_arbiter_if.master bus
);
  localparam int unsigned OW        = (N > 1) ? $clog2(N) : 1;
  localparam logic [2:0]  TURN_INIT = 3'(TURN - 1);

  if (N < 2 || N > 8 || TURN < 1 || TURN > 7 || MAXHOLD < 2 || MAXHOLD > 255) begin : g_param_check
    $error("tribus_arbiter: parameter out of range");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_GRANT,
    S_TURN
  } state_t;

  state_t        state_q;
  logic [N-1:0]  gnt_q;
  logic [OW-1:0] owner_q;
  logic [OW-1:0] ptr_q;
  logic [2:0]    turn_q;
  logic          busy_q;

  logic [N-1:0]  req_s;
  logic          pick_vld;
  logic [OW-1:0] pick_idx;
  logic          others;
  logic          revoke;
  logic          release_now;

  function automatic logic [OW-1:0] wrap_idx(input logic [OW-1:0] base, input int unsigned off);
    int unsigned s;
    s = (32'(base) + off) % N;
    return OW'(s);
  endfunction

  // Unknown request bits count as "not requesting" so X never reaches the enables.
  always_comb begin
    req_s = '0;
    for (int unsigned i = 0; i < N; i++) begin
      req_s[i] = (bus.req[i] === 1'b1);
    end
  end

  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      if (!pick_vld && req_s[wrap_idx(ptr_q, k)]) begin
        pick_vld = 1'b1;
        pick_idx = wrap_idx(ptr_q, k);
      end
    end
  end

  assign others = |(req_s & ~gnt_q);

`ifdef ARB_HOLD_LIMIT_EN
  localparam logic [7:0] HOLD_MAX = 8'(MAXHOLD);
  logic [7:0] hold_q;
  assign revoke = (hold_q == HOLD_MAX) && others;
`else
  assign revoke = 1'b0;
`endif

  assign release_now = !req_s[owner_q] || revoke;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      owner_q <= '0;
      ptr_q   <= OW'(N - 1);
      turn_q  <= '0;
      busy_q  <= 1'b0;
`ifdef ARB_HOLD_LIMIT_EN
      hold_q  <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (pick_vld) begin
            state_q <= S_GRANT;
            gnt_q   <= N'(1) << pick_idx;
            owner_q <= pick_idx;
            ptr_q   <= pick_idx;
            busy_q  <= 1'b1;
`ifdef ARB_HOLD_LIMIT_EN
            hold_q  <= 8'd1;
`endif
          end
        end
        S_GRANT: begin
          // Release always passes through TURN; no direct handoff even if others are waiting.
          if (release_now) begin
            state_q <= S_TURN;
            gnt_q   <= '0;
            turn_q  <= TURN_INIT;
          end
`ifdef ARB_HOLD_LIMIT_EN
          else if (hold_q != HOLD_MAX) begin
            hold_q <= hold_q + 8'd1;
          end
`endif
        end
        S_TURN: begin
          if (turn_q == '0) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            turn_q <= turn_q - 3'd1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          gnt_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.gnt   = gnt_q;
  assign bus.oe    = gnt_q;
  assign bus.busy  = busy_q;
  assign bus.owner = owner_q;

`ifndef SYNTHESIS
  a_req_known: assert property (@(posedge clk) disable iff (!rst)
    (state_q == S_IDLE) |-> !$isunknown(bus.req))
    else $warning("tribus_arbiter: unknown req bit in IDLE treated as 0");
`endif

endmodule

// File: tb/tb_tribus_arbiter.sv
// Scoreboard bench for tribus_arbiter: a rule-level model predicts outputs per edge,
// a monitor compares them on the falling edge; directed scenarios plus random requesters.
module tb_tribus_arbiter;
  localparam int unsigned N       = 4;
  localparam int unsigned TURN    = 1;
  localparam int unsigned MAXHOLD = 8;
  localparam int unsigned OW      = (N > 1) ? $clog2(N) : 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int n_checks = 0;
  int n_fail   = 0;

  tribus_arbiter_if #(.N(N)) bus ();

  tribus_arbiter #(
    .N       (N),
    .TURN    (TURN),
    .MAXHOLD (MAXHOLD)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0]  gnt;
    logic          busy;
    logic [OW-1:0] owner;
  } exp_t;

  exp_t sb_q[$];

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic [N-1:0] oh(int unsigned i);
    return N'(1) << i;
  endfunction

  // Reference model: owner / remaining-silence / round-robin pointer, advanced once per edge.
  initial begin : model
    int           m_owner;
    int           m_silence;
    int           m_ptr;
    int           m_last;
    int           m_hold;
    int unsigned  c;
    logic [N-1:0] r;
    logic         found;
    logic         drop;
    exp_t         e;
    m_owner = -1; m_silence = 0; m_ptr = N - 1; m_last = 0; m_hold = 0;
    forever begin
      @(posedge clk);
      r = bus.req;
      if (!rst) begin
        m_owner = -1; m_silence = 0; m_ptr = N - 1; m_last = 0; m_hold = 0;
      end else if (m_owner >= 0) begin
        drop = ((r & oh(m_owner)) == '0);
`ifdef ARB_HOLD_LIMIT_EN
        if (m_hold >= MAXHOLD && (r & ~oh(m_owner)) != '0) drop = 1'b1;
`endif
        if (drop) begin
          m_owner   = -1;
          m_silence = TURN;
        end else if (m_hold < MAXHOLD) begin
          m_hold++;
        end
      end else if (m_silence > 0) begin
        m_silence--;
      end else begin
        found = 1'b0;
        for (int k = 1; k <= N; k++) begin
          c = (m_ptr + k) % N;
          if (!found && (r & oh(c)) != '0) begin
            found   = 1'b1;
            m_owner = c;
          end
        end
        if (found) begin
          m_ptr  = m_owner;
          m_last = m_owner;
          m_hold = 1;
        end
      end
      e.gnt   = (m_owner >= 0) ? oh(m_owner) : '0;
      e.busy  = (m_owner >= 0) || (m_silence > 0);
      e.owner = m_last[OW-1:0];
      sb_q.push_back(e);
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("sb_gnt",   32'(bus.gnt),   32'(e.gnt));
        chk("sb_oe",    32'(bus.oe),    32'(e.gnt));
        chk("sb_busy",  32'(bus.busy),  32'(e.busy));
        chk("sb_owner", 32'(bus.owner), 32'(e.owner));
        chk("onehot0",  32'($onehot0(bus.gnt)), 32'd1);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic expect_gnt(string name, logic [N-1:0] g);
    chk(name, 32'(bus.gnt), 32'(g));
    chk({name, "_oe"}, 32'(bus.oe), 32'(g));
  endtask

  // Reset lands between edges; enables must fall without waiting for a clock.
  task automatic do_reset();
    @(negedge clk);
    #1;
    rst = 1'b0;
    bus.req = '0;
    #1;
    expect_gnt("async_rst_gnt", '0);
    chk("async_rst_busy", 32'(bus.busy), 32'd0);
    @(posedge clk);
    #2;
    rst = 1'b1;
  endtask

  task automatic random_phase(input int unsigned cycles);
    int           st[N];
    int           left[N];
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) begin
      st[i] = 0;
      left[i] = 0;
    end
    r = '0;
    repeat (cycles) begin
      for (int i = 0; i < N; i++) begin
        case (st[i])
          0: begin
            r[i] = 1'b0;
            if ($urandom_range(0, 5) == 0) begin
              r[i] = 1'b1;
              st[i] = 1;
            end else if ($urandom_range(0, 39) == 0) begin
              r[i] = 1'b1;
            end
          end
          1: begin
            if (bus.gnt[i]) begin
              st[i] = 2;
              left[i] = $urandom_range(1, 12);
            end
          end
          default: begin
            if (!bus.gnt[i]) begin
              st[i] = 1;
            end else begin
              left[i]--;
              if (left[i] == 0) begin
                st[i] = 0;
                r[i] = 1'b0;
              end
            end
          end
        endcase
      end
      bus.req = r;
      tick();
    end
  endtask

  initial begin : stimulus
    bus.req = '0;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    expect_gnt("reset_gnt", '0);
    chk("reset_busy",  32'(bus.busy),  32'd0);
    chk("reset_owner", 32'(bus.owner), 32'd0);

    // Rotation: everyone requests, each owner holds 3 cycles then briefly drops.
    bus.req = '1;
    tick();
    for (int g = 0; g < 5; g++) begin
      expect_gnt("rot_owner", oh(g % N));
      chk("rot_idx", 32'(bus.owner), 32'(g % N));
      tick();
      tick();
      bus.req = bus.req & ~oh(g % N);
      tick();
      expect_gnt("rot_gap1", '0);
      bus.req = bus.req | oh(g % N);
      tick();
      expect_gnt("rot_gap2", '0);
      tick();
    end
    bus.req = '0;
    repeat (4) tick();

    // Single requester, then release.
    do_reset();
    bus.req = 4'b0010;
    tick();
    expect_gnt("single_gnt", 4'b0010);
    chk("single_owner", 32'(bus.owner), 32'd1);
    repeat (3) tick();
    bus.req = '0;
    tick();
    expect_gnt("single_rel", '0);
    chk("single_busy_turn", 32'(bus.busy), 32'd1);
    tick();
    chk("single_busy_idle", 32'(bus.busy), 32'd0);

    // Reset while 2 owns the bus.
    bus.req = 4'b0100;
    tick();
    expect_gnt("pre_rst_gnt", 4'b0100);
    do_reset();

    // Contention: owner 2 drops as 0 rises, 3 already waiting.
    bus.req = 4'b0100;
    tick();
    expect_gnt("cont_own2", 4'b0100);
    bus.req = 4'b1100;
    tick();
    tick();
    bus.req = 4'b1001;
    tick();
    expect_gnt("cont_turn", '0);
    tick();
    expect_gnt("cont_idle", '0);
    tick();
    expect_gnt("cont_win3", 4'b1000);
    bus.req = '0;
    repeat (4) tick();

    // Pulse wholly inside TURN is lost.
    do_reset();
    bus.req = 4'b0001;
    tick();
    tick();
    bus.req = '0;
    tick();
    bus.req = 4'b0010;
    tick();
    bus.req = '0;
    tick();
    expect_gnt("pulse_lost1", '0);
    tick();
    expect_gnt("pulse_lost2", '0);
    chk("pulse_busy", 32'(bus.busy), 32'd0);

    // Long hold by 0 with 2 waiting.
    do_reset();
    bus.req = 4'b0101;
    tick();
    expect_gnt("hold_first", 4'b0001);
    repeat (7) tick();
    expect_gnt("hold_cycle8", 4'b0001);
    tick();
`ifdef ARB_HOLD_LIMIT_EN
    expect_gnt("hold_revoked", '0);
    tick();
    tick();
    expect_gnt("hold_next", 4'b0100);
`else
    expect_gnt("hold_kept", 4'b0001);
    repeat (12) tick();
    expect_gnt("hold_unlimited", 4'b0001);
`endif
    bus.req = '0;
    repeat (4) tick();

    // Lone long holder is never revoked.
    do_reset();
    bus.req = 4'b0001;
    tick();
    repeat (20) tick();
    expect_gnt("solo_hold", 4'b0001);
    bus.req = '0;
    repeat (4) tick();

    random_phase(3000);
    bus.req = '0;
    repeat (5) tick();
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
